conv_encoder: RTL and testbench
===============================

Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder.
- Transmit-side counterpart of the Viterbi decoder's branch-metric units. It produces the rx_pair symbol stream those units consume.
- Takes a serial bit stream per frame through a valid/ready handshake and emits one 2-bit code pair per bit.
- Appends K-1 = 2 zero tail bits so every frame ends the trellis in state 00.

Parameters:
- G0, 3'b111, generator for code bit enc_pair[1]; bit 2 taps the current input, bit 0 taps the oldest stored bit.
- G1, 3'b101, generator for code bit enc_pair[0]; same tap ordering as G0.
- TERMINATE, 1, 1 = append 2 zero tail bits per frame; 0 = no tail, shift register cleared at frame end.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_bit  input  1  data bit.
- in_valid  input  1  in_bit/in_last valid.
- in_last  input  1  in_bit is the final data bit of the frame.
- in_ready  output  1  encoder can accept a bit this cycle (combinational).
- enc_pair  output  2  code pair {g0 bit, g1 bit}, registered.
- out_valid  output  1  enc_pair valid.
- out_last  output  1  enc_pair is the final pair of the frame.
- out_ready  input  1  downstream accepts enc_pair.
- busy  output  1  frame in progress (state != IDLE or out_valid).

Behaviour:
- Shift register sr[1:0]; sr[1] is the most recent bit. Window w = {b, sr[1], sr[0]}, where b = in_bit or the tail 0.
- Code bits: enc_pair[1] = ^(w & G0); enc_pair[0] = ^(w & G1).
- On each produced pair: sr <= {b, sr[1]}.
- Output stage is a single register: pair launches when the output is free (out_free = !out_valid || out_ready).
- Latency is 1 cycle from the input handshake to out_valid.
- Full throughput is 1 pair/cycle when out_ready is held high.
- out_valid and enc_pair hold stable while out_valid && !out_ready.
- FSM states IDLE, DATA, TAIL:
  - IDLE: in_ready = out_free. Accept (in_valid && in_ready) loads a pair.
    - in_last = 0 -> DATA.
    - in_last = 1 -> TAIL if TERMINATE, else stay in IDLE.
  - DATA: in_ready = out_free. Accept with in_last = 1 -> TAIL (TERMINATE = 1) or IDLE (TERMINATE = 0, sr <= 00 after the pair is formed, out_last = 1).
  - TAIL: in_ready = 0. Tail counter tcnt (1 bit) starts at 0. Each cycle with out_free, load the pair for b = 0 and increment tcnt. The second tail pair has out_last = 1 and the FSM goes to IDLE; sr is then 00 naturally.
- out_last is asserted only with out_valid and clears when that pair is accepted.
- in_valid low in DATA: no pair is produced and sr holds. Gaps are allowed anywhere inside a frame.
- in_valid is ignored while in_ready = 0. No bit may be lost or duplicated under backpressure.
- Reset (any state, including mid-tail or mid-stall):
  - Next cycle: state IDLE, sr 00, tcnt 0, out_valid 0, enc_pair 00, out_last 0, busy 0.
  - in_ready = 1.
- Simultaneous events: the output pair being accepted and a new input accepted in the same cycle is legal. The new pair replaces the old one with no bubble.

Test Plan:
- Reset, then bits 1,0,1,1 (last on the 4th bit), out_ready = 1 -> pairs 11,10,00,01,01,11. out_last only on the 6th pair; busy drops after it; in_ready = 0 for 2 cycles.
- Single-bit frame: bit 1 with last -> 11,10,11 with out_last on 11 (3rd pair). The following frame's first bit 1 gives 11 again (sr returned to 00).
- Backpressure: first test stream with out_ready toggled 1,0,0,1,0,1,... -> identical pair sequence. enc_pair stable during stalls; in_ready = 0 whenever out_valid && !out_ready.
- Input gaps: 1,0,1,1 with in_valid low for 3 cycles between bits 2 and 3 -> the same 6 pairs and no spurious out_valid.
- Reset mid-tail: assert rst while the first tail pair is valid -> next cycle out_valid = 0, busy = 0, in_ready = 1. A fresh frame with bit 0, last -> 00,00,00.
- TERMINATE = 0: bits 1,1 last -> 11,01 with out_last on 01. Next frame with bit 1 -> 11.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready streaming and optional
// zero-tail termination so every frame leaves the trellis in state 00.
module conv_encoder #(
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101,
  parameter bit         TERMINATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] enc_pair,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds data stable while valid && !ready, and ready never waits on valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] sr_q, sr_d;
  logic       tcnt_q, tcnt_d;
  logic [1:0] enc_q, enc_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;

  logic       out_free;
  logic       accept;
  logic       tail_step;
  logic       b;
  logic [2:0] w;
  logic [1:0] pair;

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = (state_q != TAIL) && out_free;
    accept    = in_valid && in_ready;
    tail_step = (state_q == TAIL) && out_free;
    b         = accept ? in_bit : 1'b0;
    w         = {b, sr_q};
    pair      = {^(w & G0), ^(w & G1)};

    state_d     = state_q;
    sr_d        = sr_q;
    tcnt_d      = tcnt_q;
    enc_d       = enc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      enc_d       = pair;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      sr_d        = {b, sr_q[1]};
      if (in_last) begin
        if (TERMINATE) begin
          state_d = TAIL;
          tcnt_d  = 1'b0;
        end else begin
          // Unterminated frames still start the next frame from a clean register.
          state_d    = IDLE;
          sr_d       = 2'b00;
          out_last_d = 1'b1;
        end
      end else begin
        state_d = DATA;
      end
    end else if (tail_step) begin
      enc_d       = pair;
      out_valid_d = 1'b1;
      sr_d        = {1'b0, sr_q[1]};
      tcnt_d      = tcnt_q + 1'b1;
      out_last_d  = tcnt_q;
      if (tcnt_q) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= 2'b00;
      tcnt_q      <= 1'b0;
      enc_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tcnt_q      <= tcnt_d;
      enc_q       <= enc_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign enc_pair  = enc_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: terminated instance (a_*) and an
// unterminated instance (b_*), each with a scoreboard of {last, pair} entries.
module tb_conv_encoder;

  logic       clk;
  logic       rst;

  logic       in_bit, in_valid, in_last, in_ready;
  logic [1:0] enc_pair;
  logic       out_valid, out_last, out_ready, busy;

  logic       b_in_bit, b_in_valid, b_in_last, b_in_ready;
  logic [1:0] b_enc_pair;
  logic       b_out_valid, b_out_last, b_out_ready, b_busy;

  logic [2:0] exp_q[$];
  logic [2:0] expb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic bp_en  = 1'b0;

  conv_encoder #(.G0(3'b111), .G1(3'b101), .TERMINATE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .enc_pair(enc_pair), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  conv_encoder #(.G0(3'b111), .G1(3'b101), .TERMINATE(1'b0)) u_dut_nt (
    .clk(clk), .rst(rst), .in_bit(b_in_bit), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .enc_pair(b_enc_pair), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_ready(b_out_ready), .busy(b_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push(input logic [1:0] pair, input logic last);
    exp_q.push_back({last, pair});
  endtask

  task automatic pushb(input logic [1:0] pair, input logic last);
    expb_q.push_back({last, pair});
  endtask

  // driver tasks: called and return at posedge+1
  task automatic send_bit(input logic bit_v, input logic last);
    int t = 0;
    in_bit = bit_v; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_timeout", t < 200, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0;
  endtask

  task automatic send_bit_b(input logic bit_v, input logic last);
    int t = 0;
    b_in_bit = bit_v; b_in_last = last; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("b_in_ready_timeout", t < 200, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_bit = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || b_busy || exp_q.size() != 0 || expb_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < 500, 1);
    @(posedge clk); #1;
  endtask

  // out_ready driver: pattern 1,0,0,1,0,1 repeating when backpressure is on
  initial begin
    int pidx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        out_ready = (pidx == 0) || (pidx == 3) || (pidx == 5);
        pidx = (pidx == 5) ? 0 : pidx + 1;
      end else begin
        out_ready = 1'b1;
        pidx = 0;
      end
    end
  end

  // scoreboard / stall monitor for the terminated instance
  initial begin
    logic       stalled = 1'b0;
    logic [1:0] held = 2'b00;
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_pair", enc_pair, held);
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pair", {out_last, enc_pair}, e);
          end
        end
        stalled = out_valid && !out_ready;
        if (stalled) begin
          held = enc_pair;
          check("stall_in_ready", in_ready, 0);
        end
      end
    end
  end

  // scoreboard for the unterminated instance
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (!rst && b_out_valid && b_out_ready) begin
        check("b_sb_nonempty", expb_q.size() != 0, 1);
        if (expb_q.size() != 0) begin
          e = expb_q.pop_front();
          check("b_pair", {b_out_last, b_enc_pair}, e);
        end
      end
    end
  end

  task automatic push_stream1();
    push(2'b11, 0); push(2'b10, 0); push(2'b00, 0);
    push(2'b01, 0); push(2'b01, 0); push(2'b11, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_bit = 0; in_valid = 0; in_last = 0;
    b_in_bit = 0; b_in_valid = 0; b_in_last = 0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_enc_pair", enc_pair, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic frame 1,0,1,1 with tail
    push_stream1();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    @(negedge clk); check("tail_in_ready_0", in_ready, 0);
    @(negedge clk); check("tail_in_ready_1", in_ready, 0);
    @(negedge clk); check("end_in_ready", in_ready, 1);
    check("end_busy_last_pair", busy, 1);
    @(negedge clk); check("end_busy_clear", busy, 0);
    @(posedge clk); #1;
    wait_idle();

    // single-bit frames back to back
    push(2'b11, 0); push(2'b10, 0); push(2'b11, 1);
    push(2'b11, 0); push(2'b10, 0); push(2'b11, 1);
    send_bit(1, 1);
    send_bit(1, 1);
    wait_idle();

    // backpressure
    bp_en = 1'b1;
    push_stream1();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    wait_idle();
    bp_en = 1'b0;
    @(posedge clk); #1;

    // input gaps
    push_stream1();
    send_bit(1, 0); send_bit(0, 0);
    repeat (3) @(posedge clk);
    #1;
    send_bit(1, 0); send_bit(1, 1);
    wait_idle();

    // reset while the first tail pair is valid
    push(2'b11, 0); push(2'b10, 0); push(2'b00, 0); push(2'b01, 0);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    @(posedge clk); #1;
    check("pre_rst_tail_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midtail_rst_out_valid", out_valid, 0);
    check("midtail_rst_busy", busy, 0);
    check("midtail_rst_in_ready", in_ready, 1);
    check("midtail_rst_out_last", out_last, 0);
    @(posedge clk); #1;
    push(2'b00, 0); push(2'b00, 0); push(2'b00, 1);
    send_bit(0, 1);
    wait_idle();

    // unterminated instance
    pushb(2'b11, 0); pushb(2'b01, 1); pushb(2'b11, 1);
    send_bit_b(1, 0); send_bit_b(1, 1);
    send_bit_b(1, 1);
    wait_idle();
    check("final_sb_empty", exp_q.size() + expb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
